uart_cfg: RTL and testbench
===========================

# uart_cfg

Parametrised full-duplex UART for the hardware-test path: configurable data width, stop bits and optional parity, with receive error reporting (framing, parity, overrun) and glitch rejection on the start bit. It replaces the fixed 8N1 UART between the board serial pins and the test-control logic. It uses a valid/ready byte interface on both directions, one data register per direction.

## Interface
- CLKRATE, 50000000, clk frequency in Hz
- BAUDRATE, 115200, line rate; BAUD_DIV = CLKRATE/BAUDRATE (integer division), must be >= 4
- DATA_BITS, 8, data bits per frame, legal 5..8
- STOP_BITS, 1, stop bits per frame, legal 1 or 2
- PARITY, 0, 0 none / 1 odd / 2 even (effective only with UART_PARITY_EN)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- rx  in  1  serial input, asynchronous to clk
- tx  out  1  serial output, idle high
- tvalid  in  1  transmit byte offered
- tready  out  1  transmitter idle, accepts byte
- tdata  in  DATA_BITS  transmit data, LSB sent first
- rvalid  out  1  received byte held
- rready  in  1  consumer accepts received byte
- rdata  out  DATA_BITS  received data
- rx_frame_err  out  1  a stop bit of the held byte sampled 0; qualified by rvalid
- rx_parity_err  out  1  parity mismatch on the held byte; qualified by rvalid
- rx_overrun  out  1  the held byte overwrote an unread byte; qualified by rvalid

## Operation
- Reset (rst=0 at a clk edge): tx=1, tready=0, rvalid=0, rdata=0, all error flags 0, both FSMs IDLE, synchroniser flops=1. Reset applied mid-frame aborts the frame immediately; the partial RX byte is dropped.
- Baud timing: each direction has an independent counter, width $clog2(BAUD_DIV), and each bit lasts exactly BAUD_DIV clk.
- TX FSM: IDLE -> START -> DATA (DATA_BITS bits) -> PARITY (only if enabled and PARITY!=0) -> STOP (STOP_BITS bits) -> IDLE.
  - tready=1 only in IDLE, not in reset.
  - A handshake (tvalid & tready) latches tdata and enters START. tready drops on the next edge.
  - tdata is ignored while tready=0.
- Parity covers the data bits only:
  - odd: data ones plus parity bit is odd.
  - even: data ones plus parity bit is even.
- RX path: rx passes through a 2-flop synchroniser (rxs).
- RX FSM: IDLE -> START -> DATA -> PARITY (optional) -> STOP -> IDLE.
  - IDLE leaves on rxs=0.
  - START samples after BAUD_DIV/2 clk. If rxs=1, it returns to IDLE with no output (glitch).
  - Later samples are taken every BAUD_DIV clk at bit centre.
  - Data is shifted LSB first.
  - Every stop bit is sampled; any 0 sets the frame error.
- Byte completion happens on the final stop sample, in the same edge:
  - rdata, rx_frame_err and rx_parity_err are loaded, rvalid=1, and the FSM returns to IDLE.
  - After a framing error, IDLE re-arms only after rxs has been seen high (break does not retrigger).
- Overrun: if rvalid=1 with no handshake on the completion edge, the new byte overwrites rdata and rx_overrun=1.
- rvalid & rready clears rvalid and all three flags on the next edge.
- Simultaneous handshake and completion on the same edge: the new byte is loaded, rvalid stays 1, rx_overrun=0.

## Timing
- TX: tx goes low on the edge after the handshake edge. Frame length is F*BAUD_DIV clk, where F = 1+DATA_BITS+P+STOP_BITS and P=1 if parity is enabled.
- tready returns to 1 on the edge ending the last stop bit. Back-to-back frames therefore have no idle gap beyond 1 clk.
- RX: rvalid rises 2 + BAUD_DIV/2 + (F-1)*BAUD_DIV clk after the first edge that registers rx=0 in the first synchroniser flop.
- tx, tready, rvalid, rdata and the flags are all registered outputs.

## Configuration
- UART_PARITY_EN defined: the PARITY parameter is honoured, TX inserts the parity bit, and RX checks it and drives rx_parity_err.
- Undefined: PARITY is ignored, frames never contain a parity bit, and rx_parity_err is constant 0.

## Test plan
All scenarios use CLKRATE=50000000, BAUDRATE=5000000 (BAUD_DIV=10), unless noted.
- Reset/idle:
  - Stimulus: rst=0 for 5 clk, then 1.
  - Required: tx=1 and rvalid=0 throughout; tready=1 from the first edge with rst=1.
- TX 8N1:
  - Stimulus: send 0xA5.
  - Required: tx holds 0,1,0,1,0,0,1,0,1,1 for 10 clk each; tready=1 exactly 100 clk after the handshake.
- Loopback with tx->rx, UART_PARITY_EN defined, PARITY=2, STOP_BITS=2, DATA_BITS=7:
  - Stimulus: send 0x55.
  - Required: rdata=0x55, rvalid=1, all flags 0.
- RX errors:
  - Stimulus: drive frame 0x3C with stop=0.
  - Required: rvalid=1, rdata=0x3C, rx_frame_err=1; no new frame is accepted until rx returns high.
- Glitch/overrun:
  - Stimulus 1: a 3-clk low pulse on rx. Required: no rvalid.
  - Stimulus 2: two frames 0x11, 0x22 with rready=0. Required: rdata=0x22, rx_overrun=1; rready clears all.
- Reset mid-frame:
  - Stimulus: rst=0 during TX data bit 3.
  - Required: tx=1 next edge; no rvalid from the truncated RX frame.

Source files
------------

// File: rtl/uart_cfg.sv
// Full-duplex UART with configurable data/stop bits, start-bit glitch rejection and RX error flags.
// Parity insertion and checking are compiled in only when UART_PARITY_EN is defined.
module uart_cfg #(
  parameter int CLKRATE   = 50000000,
  parameter int BAUDRATE  = 115200,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int PARITY    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic                 tx,
  input  logic                 tvalid,
  output logic                 tready,
  input  logic [DATA_BITS-1:0] tdata,
  output logic                 rvalid,
  input  logic                 rready,
  output logic [DATA_BITS-1:0] rdata,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun
);

  localparam int BAUD_DIV = CLKRATE / BAUDRATE;
  localparam int CW = $clog2(BAUD_DIV);
  localparam int BW = $clog2(DATA_BITS);
`ifdef UART_PARITY_EN
  localparam bit PAR_EN = (PARITY != 0);
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam bit PAR_ODD = (PARITY == 1);
  localparam logic STOP_LAST = (STOP_BITS == 2);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
  localparam logic [BW-1:0] IDX_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               tx_state;
  logic [CW-1:0]        tx_cnt;
  logic [DATA_BITS-1:0] tx_shift;
  logic [BW-1:0]        tx_idx;
  logic                 tx_stop_idx;
  logic                 tx_par;
  logic                 tx_tick;

  assign tx_tick = (tx_cnt == '0);

  // tx is the registered image of the current state's line level, so the line lags the FSM by one clk
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_state    <= S_IDLE;
      tx_cnt      <= '0;
      tx_shift    <= '0;
      tx_idx      <= '0;
      tx_stop_idx <= 1'b0;
      tx_par      <= 1'b0;
      tx          <= 1'b1;
      tready      <= 1'b0;
    end else begin
      case (tx_state)
        S_START:  tx <= 1'b0;
        S_DATA:   tx <= tx_shift[0];
        S_PARITY: tx <= tx_par;
        default:  tx <= 1'b1;
      endcase
      case (tx_state)
        S_IDLE: begin
          if (tvalid && tready) begin
            tx_state <= S_START;
            tready   <= 1'b0;
            tx_shift <= tdata;
            tx_par   <= PAR_ODD ? ~^tdata : ^tdata;
            tx_cnt   <= BIT_LAST;
          end else begin
            tready <= 1'b1;
          end
        end
        S_START: begin
          if (tx_tick) begin
            tx_state <= S_DATA;
            tx_cnt   <= BIT_LAST;
            tx_idx   <= '0;
          end else tx_cnt <= tx_cnt - 1'b1;
        end
        S_DATA: begin
          if (tx_tick) begin
            tx_cnt   <= BIT_LAST;
            tx_shift <= tx_shift >> 1;
            if (tx_idx == IDX_LAST) begin
              tx_state    <= PAR_EN ? S_PARITY : S_STOP;
              tx_stop_idx <= 1'b0;
            end else tx_idx <= tx_idx + 1'b1;
          end else tx_cnt <= tx_cnt - 1'b1;
        end
        S_PARITY: begin
          if (tx_tick) begin
            tx_state    <= S_STOP;
            tx_cnt      <= BIT_LAST;
            tx_stop_idx <= 1'b0;
          end else tx_cnt <= tx_cnt - 1'b1;
        end
        S_STOP: begin
          if (tx_tick) begin
            if (tx_stop_idx == STOP_LAST) begin
              tx_state <= S_IDLE;
              tready   <= 1'b1;
            end else begin
              tx_stop_idx <= 1'b1;
              tx_cnt      <= BIT_LAST;
            end
          end else tx_cnt <= tx_cnt - 1'b1;
        end
        default: tx_state <= S_IDLE;
      endcase
    end
  end

  logic                 rx_meta, rxs;
  state_t               rx_state;
  logic [CW-1:0]        rx_cnt;
  logic [DATA_BITS-1:0] rx_shift;
  logic [BW-1:0]        rx_idx;
  logic                 rx_stop_idx;
  logic                 rx_ferr, rx_perr, rx_armed;
  logic                 rx_tick, rx_done;

  assign rx_tick = (rx_cnt == '0);
  assign rx_done = (rx_state == S_STOP) && rx_tick && (rx_stop_idx == STOP_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_state      <= S_IDLE;
      rx_cnt        <= '0;
      rx_shift      <= '0;
      rx_idx        <= '0;
      rx_stop_idx   <= 1'b0;
      rx_ferr       <= 1'b0;
      rx_perr       <= 1'b0;
      rx_armed      <= 1'b1;
      rvalid        <= 1'b0;
      rdata         <= '0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      case (rx_state)
        S_IDLE: begin
          if (rxs) rx_armed <= 1'b1;
          if (!rxs && rx_armed) begin
            rx_state <= S_START;
            rx_cnt   <= HALF_LAST;
          end
        end
        S_START: begin
          if (rx_tick) begin
            if (rxs) rx_state <= S_IDLE;
            else begin
              rx_state <= S_DATA;
              rx_cnt   <= BIT_LAST;
              rx_idx   <= '0;
              rx_ferr  <= 1'b0;
              rx_perr  <= 1'b0;
            end
          end else rx_cnt <= rx_cnt - 1'b1;
        end
        S_DATA: begin
          if (rx_tick) begin
            rx_shift <= {rxs, rx_shift[DATA_BITS-1:1]};
            rx_cnt   <= BIT_LAST;
            if (rx_idx == IDX_LAST) begin
              rx_state    <= PAR_EN ? S_PARITY : S_STOP;
              rx_stop_idx <= 1'b0;
            end else rx_idx <= rx_idx + 1'b1;
          end else rx_cnt <= rx_cnt - 1'b1;
        end
        S_PARITY: begin
          if (rx_tick) begin
            rx_perr     <= (^{rx_shift, rxs}) != PAR_ODD;
            rx_state    <= S_STOP;
            rx_cnt      <= BIT_LAST;
            rx_stop_idx <= 1'b0;
          end else rx_cnt <= rx_cnt - 1'b1;
        end
        S_STOP: begin
          if (rx_tick) begin
            if (!rxs) rx_ferr <= 1'b1;
            if (rx_stop_idx == STOP_LAST) begin
              rx_state <= S_IDLE;
              // a break must go high again before the next start bit is accepted
              if (rx_ferr || !rxs) rx_armed <= 1'b0;
            end else begin
              rx_stop_idx <= 1'b1;
              rx_cnt      <= BIT_LAST;
            end
          end else rx_cnt <= rx_cnt - 1'b1;
        end
        default: rx_state <= S_IDLE;
      endcase

      if (rx_done) begin
        rvalid        <= 1'b1;
        rdata         <= rx_shift;
        rx_frame_err  <= rx_ferr | ~rxs;
        rx_parity_err <= PAR_EN & rx_perr;
        rx_overrun    <= rvalid & ~rready;
      end else if (rvalid && rready) begin
        rvalid        <= 1'b0;
        rx_frame_err  <= 1'b0;
        rx_parity_err <= 1'b0;
        rx_overrun    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_cfg.sv
// Bench for uart_cfg: an 8N1 instance driven/observed directly and a 7-bit, 2-stop, even-parity
// instance used for loopback; expected line bits and flags come from a frame-level model.
module tb_uart_cfg;
  localparam int BD = 10;
`ifdef UART_PARITY_EN
  localparam int PAR_B = 2;
  localparam int NPT = 2;
`else
  localparam int PAR_B = 0;
  localparam int NPT = 1;
`endif
  localparam int FB = 1 + 7 + ((PAR_B != 0) ? 1 : 0) + 2;

  logic clk, rst;
  int errors, checks;

  logic rx_a, tx_a, tvalid_a, tready_a, rvalid_a, rready_a, fe_a, pe_a, ov_a;
  logic [7:0] tdata_a, rdata_a;
  logic rx_b, rx_b_drv, lb, tx_b, tvalid_b, tready_b, rvalid_b, rready_b, fe_b, pe_b, ov_b;
  logic [6:0] tdata_b, rdata_b;

  assign rx_b = lb ? tx_b : rx_b_drv;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_cfg #(.CLKRATE(50000000), .BAUDRATE(5000000)) dut_a (
    .clk(clk), .rst(rst), .rx(rx_a), .tx(tx_a), .tvalid(tvalid_a), .tready(tready_a),
    .tdata(tdata_a), .rvalid(rvalid_a), .rready(rready_a), .rdata(rdata_a),
    .rx_frame_err(fe_a), .rx_parity_err(pe_a), .rx_overrun(ov_a));

  uart_cfg #(.CLKRATE(50000000), .BAUDRATE(5000000), .DATA_BITS(7), .STOP_BITS(2), .PARITY(2)) dut_b (
    .clk(clk), .rst(rst), .rx(rx_b), .tx(tx_b), .tvalid(tvalid_b), .tready(tready_b),
    .tdata(tdata_b), .rvalid(rvalid_b), .rready(rready_b), .rdata(rdata_b),
    .rx_frame_err(fe_b), .rx_parity_err(pe_b), .rx_overrun(ov_b));

  // Line-level frame: start, data LSB first, optional parity over data, stop bits.
  task automatic build_frame(input logic [7:0] d, input int nbits, input int par, input int stops,
                             input bit bad_stop, input bit bad_par, output logic [15:0] f, output int n);
    int ones;
    ones = 0;
    f = '1;
    n = 0;
    f[n] = 1'b0; n++;
    for (int i = 0; i < nbits; i++) begin
      f[n] = d[i]; ones += int'(d[i]); n++;
    end
    if (par != 0) begin
      f[n] = 1'(((ones % 2 == 1) == (par == 2)) ^ bad_par); n++;
    end
    for (int i = 0; i < stops; i++) begin
      f[n] = ~bad_stop; n++;
    end
  endtask

  // Called one #1 after the handshake edge; samples the whole frame and tready.
  task automatic send_frame_a(input logic [7:0] d, input bit keep, input logic [7:0] nd);
    logic [15:0] f;
    logic [159:0] seen, expw;
    int n;
    bit early, end_rdy;
    build_frame(d, 8, 0, 1, 1'b0, 1'b0, f, n);
    tvalid_a = keep;
    tdata_a = keep ? nd : 8'($urandom);
    seen = '0; expw = '0; early = 0; end_rdy = 0;
    for (int i = 0; i < n * BD; i++) begin
      @(posedge clk); #1;
      seen[i] = tx_a;
      expw[i] = f[i / BD];
      if (i < n * BD - 1 && tready_a) early = 1;
      if (i == n * BD - 1) end_rdy = tready_a;
    end
    checks++;
    if (seen !== expw) begin
      errors++; $display("FAIL tx_frame d=%h: got %h expected %h", d, seen, expw);
    end
    checks++;
    if (early) begin
      errors++; $display("FAIL tready_early d=%h: got 1 expected 0 during frame", d);
    end
    checks++;
    if (end_rdy !== 1'b1) begin
      errors++; $display("FAIL tready_return d=%h: got %b expected 1", d, end_rdy);
    end
  endtask

  task automatic wait_ready_a();
    int k;
    k = 0;
    while (tready_a !== 1'b1 && k < 300) begin @(posedge clk); #1; k++; end
    checks++;
    if (tready_a !== 1'b1) begin errors++; $display("FAIL tready_a_timeout: got %b expected 1", tready_a); end
  endtask

  task automatic drive_rx(input int which, input logic [15:0] f, input int n, input logic idle_after,
                          output int rise);
    rise = -1;
    for (int bi = 0; bi < n; bi++) begin
      if (which == 0) rx_a = f[bi]; else rx_b_drv = f[bi];
      for (int c = 0; c < BD; c++) begin
        @(posedge clk); #1;
        if (rise < 0 && ((which == 0) ? rvalid_a : rvalid_b) === 1'b1) rise = bi * BD + c;
      end
    end
    if (which == 0) rx_a = idle_after; else rx_b_drv = idle_after;
  endtask

  task automatic pulse_rready_a();
    rready_a = 1'b1; @(posedge clk); #1; rready_a = 1'b0;
    checks++;
    if ({rvalid_a, fe_a, pe_a, ov_a} !== 4'b0) begin
      errors++; $display("FAIL rready_clear_a: got %b expected 0000", {rvalid_a, fe_a, pe_a, ov_a});
    end
  endtask

  task automatic test_reset();
    bit bad;
    bad = 0;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (tx_a !== 1'b1 || tx_b !== 1'b1 || rvalid_a !== 1'b0 || rvalid_b !== 1'b0 ||
          tready_a !== 1'b0 || tready_b !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL reset_hold: got outputs off during reset expected tx=1 tready=0 rvalid=0"); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({tready_a, tready_b, tx_a, tx_b, rvalid_a, rvalid_b} !== 6'b111100 || rdata_a !== 8'h00 ||
        {fe_a, pe_a, ov_a} !== 3'b000) begin
      errors++;
      $display("FAIL reset_release: got rdy=%b%b tx=%b%b rv=%b%b rdata=%h expected 11 11 00 00",
               tready_a, tready_b, tx_a, tx_b, rvalid_a, rvalid_b, rdata_a);
    end
  endtask

  task automatic test_tx_8n1();
    logic [7:0] d;
    for (int i = 0; i < 6; i++) begin
      d = (i == 0) ? 8'hA5 : 8'($urandom);
      wait_ready_a();
      tvalid_a = 1'b1; tdata_a = d;
      @(posedge clk); #1;
      send_frame_a(d, 1'b0, 8'h00);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d1, d2;
    d1 = 8'($urandom); d2 = 8'($urandom);
    wait_ready_a();
    tvalid_a = 1'b1; tdata_a = d1;
    @(posedge clk); #1;
    send_frame_a(d1, 1'b1, d2);
    @(posedge clk); #1;
    checks++;
    if ({tx_a, tready_a} !== 2'b10) begin
      errors++; $display("FAIL b2b_gap: got tx=%b tready=%b expected tx=1 tready=0", tx_a, tready_a);
    end
    send_frame_a(d2, 1'b0, 8'h00);
  endtask

  task automatic test_rx_random();
    logic [15:0] f;
    logic [7:0] d;
    int n, rise;
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom);
      build_frame(d, 8, 0, 1, 1'b0, 1'b0, f, n);
      drive_rx(0, f, n, 1'b1, rise);
      checks++;
      if (rise !== 2 + BD / 2 + (n - 1) * BD) begin
        errors++; $display("FAIL rx_latency: got %0d expected %0d", rise, 2 + BD / 2 + (n - 1) * BD);
      end
      checks++;
      if (rvalid_a !== 1'b1 || rdata_a !== d) begin
        errors++; $display("FAIL rx_data: got rv=%b %h expected 1 %h", rvalid_a, rdata_a, d);
      end
      checks++;
      if ({fe_a, pe_a, ov_a} !== 3'b000) begin
        errors++; $display("FAIL rx_flags: got %b expected 000", {fe_a, pe_a, ov_a});
      end
      repeat ($urandom_range(0, 4)) @(posedge clk);
      #1 pulse_rready_a();
    end
  endtask

  task automatic test_rx_errors();
    logic [15:0] f;
    logic [7:0] d;
    int n, rise;
    bit seen;
    build_frame(8'h3C, 8, 0, 1, 1'b1, 1'b0, f, n);
    drive_rx(0, f, n, 1'b0, rise);
    checks++;
    if ({rvalid_a, fe_a, pe_a, ov_a} !== 4'b1100 || rdata_a !== 8'h3C) begin
      errors++; $display("FAIL rx_frame_err: got rv/fe/pe/ov=%b data=%h expected 1100 3c",
                         {rvalid_a, fe_a, pe_a, ov_a}, rdata_a);
    end
    pulse_rready_a();
    seen = 0;
    repeat (150) begin @(posedge clk); #1; if (rvalid_a) seen = 1; end
    checks++;
    if (seen) begin errors++; $display("FAIL break_rearm: got rvalid=1 expected 0 while rx held low"); end
    rx_a = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    d = 8'($urandom);
    build_frame(d, 8, 0, 1, 1'b0, 1'b0, f, n);
    drive_rx(0, f, n, 1'b1, rise);
    checks++;
    if (rvalid_a !== 1'b1 || rdata_a !== d || fe_a !== 1'b0) begin
      errors++; $display("FAIL rx_after_break: got rv=%b %h fe=%b expected 1 %h 0", rvalid_a, rdata_a, fe_a, d);
    end
    pulse_rready_a();
  endtask

  task automatic test_glitch();
    bit seen;
    seen = 0;
    rx_a = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx_a = 1'b1;
    repeat (60) begin @(posedge clk); #1; if (rvalid_a) seen = 1; end
    checks++;
    if (seen) begin errors++; $display("FAIL glitch: got rvalid=1 expected 0"); end
  endtask

  task automatic test_overrun();
    logic [15:0] f;
    int n, rise;
    rready_a = 1'b0;
    build_frame(8'h11, 8, 0, 1, 1'b0, 1'b0, f, n);
    drive_rx(0, f, n, 1'b1, rise);
    checks++;
    if (rvalid_a !== 1'b1 || rdata_a !== 8'h11 || ov_a !== 1'b0) begin
      errors++; $display("FAIL overrun_first: got rv=%b %h ov=%b expected 1 11 0", rvalid_a, rdata_a, ov_a);
    end
    build_frame(8'h22, 8, 0, 1, 1'b0, 1'b0, f, n);
    drive_rx(0, f, n, 1'b1, rise);
    checks++;
    if ({rvalid_a, fe_a, pe_a, ov_a} !== 4'b1001 || rdata_a !== 8'h22) begin
      errors++; $display("FAIL overrun: got rv/fe/pe/ov=%b data=%h expected 1001 22",
                         {rvalid_a, fe_a, pe_a, ov_a}, rdata_a);
    end
    pulse_rready_a();
  endtask

  task automatic loopback_one(input logic [6:0] d);
    int k;
    k = 0;
    while (tready_b !== 1'b1 && k < 300) begin @(posedge clk); #1; k++; end
    tvalid_b = 1'b1; tdata_b = d;
    @(posedge clk); #1;
    tvalid_b = 1'b0; tdata_b = 7'($urandom);
    k = 0;
    while (rvalid_b !== 1'b1 && k < 400) begin @(posedge clk); #1; k++; end
    checks++;
    if (rvalid_b !== 1'b1 || rdata_b !== d || {fe_b, pe_b, ov_b} !== 3'b000) begin
      errors++; $display("FAIL loopback: got rv=%b %h flags=%b expected 1 %h 000",
                         rvalid_b, rdata_b, {fe_b, pe_b, ov_b}, d);
    end
    checks++;
    if (k < (FB - 1) * BD || k > FB * BD + 4) begin
      errors++; $display("FAIL loopback_latency: got %0d clk expected near %0d", k, FB * BD);
    end
    rready_b = 1'b1; @(posedge clk); #1; rready_b = 1'b0;
    checks++;
    if (rvalid_b !== 1'b0) begin errors++; $display("FAIL loopback_clear: got %b expected 0", rvalid_b); end
  endtask

  task automatic test_loopback();
    lb = 1'b1;
    loopback_one(7'h55);
    for (int i = 0; i < 4; i++) loopback_one(7'($urandom));
  endtask

  task automatic test_parity();
    logic [15:0] f;
    logic [6:0] d;
    int n, rise;
    lb = 1'b0;
    for (int bad = 0; bad < NPT; bad++) begin
      d = 7'($urandom);
      build_frame({1'b0, d}, 7, PAR_B, 2, 1'b0, bad[0], f, n);
      drive_rx(1, f, n, 1'b1, rise);
      checks++;
      if (rvalid_b !== 1'b1 || rdata_b !== d || pe_b !== bad[0] || fe_b !== 1'b0) begin
        errors++; $display("FAIL parity bad=%0d: got rv=%b %h pe=%b fe=%b expected 1 %h %0d 0",
                           bad, rvalid_b, rdata_b, pe_b, fe_b, d, bad);
      end
      checks++;
      if (rise !== 2 + BD / 2 + (n - 1) * BD) begin
        errors++; $display("FAIL rx_b_latency: got %0d expected %0d", rise, 2 + BD / 2 + (n - 1) * BD);
      end
      rready_b = 1'b1; @(posedge clk); #1; rready_b = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    int k;
    lb = 1'b1;
    k = 0;
    while (tready_b !== 1'b1 && k < 300) begin @(posedge clk); #1; k++; end
    tvalid_b = 1'b1; tdata_b = 7'h00;
    @(posedge clk); #1;
    tvalid_b = 1'b0;
    repeat (44) @(posedge clk);
    #1;
    checks++;
    if (tx_b !== 1'b0) begin errors++; $display("FAIL mid_bit3_level: got %b expected 0", tx_b); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({tx_b, tready_b, rvalid_b} !== 3'b100) begin
      errors++; $display("FAIL mid_reset: got tx/tready/rvalid=%b expected 100", {tx_b, tready_b, rvalid_b});
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    seen = 0;
    repeat (200) begin @(posedge clk); #1; if (rvalid_b) seen = 1; end
    checks++;
    if (seen) begin errors++; $display("FAIL mid_reset_rx: got rvalid=1 expected 0"); end
    loopback_one(7'($urandom));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    errors = 0; checks = 0;
    rst = 1'b0; rx_a = 1'b1; rx_b_drv = 1'b1; lb = 1'b0;
    tvalid_a = 1'b0; tdata_a = '0; rready_a = 1'b0;
    tvalid_b = 1'b0; tdata_b = '0; rready_b = 1'b0;
    test_reset();
    test_tx_8n1();
    test_back_to_back();
    test_rx_random();
    test_rx_errors();
    test_glitch();
    test_overrun();
    test_loopback();
    test_parity();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
